// File: rtl/adc_stream_pack.sv
// N-channel ADC sample formatter with shared decimation and per-channel
// FIFO-backed AXI-stream outputs, overrange tagging and drop accounting.
module adc_stream_pack #(
  parameter int NUM_CH      = 2,
  parameter int DATA_WIDTH  = 14,
  parameter int TDATA_WIDTH = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                          m_axis_aclk,
  input  logic                          m_axis_areset,
  input  logic                          enable,
  input  logic                          fmt_signed,
  input  logic [DECIM_WIDTH-1:0]        decim,
  input  logic                          adc_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  adc_data,
  input  logic [NUM_CH-1:0]             adc_or,
  input  logic                          or_clear,
  output logic [NUM_CH-1:0]             m_axis_tvalid,
  input  logic [NUM_CH-1:0]             m_axis_tready,
  output logic [NUM_CH*TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [NUM_CH-1:0]             m_axis_tuser,
  output logic [NUM_CH-1:0]             ovf_sticky,
  output logic [NUM_CH*16-1:0]          drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TDATA_WIDTH + 1;
  localparam logic [CW-1:0]          FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]          CNT_ZERO = CW'(0);
  localparam logic [AW-1:0]          PTR_ONE  = AW'(1);
  localparam logic [AW-1:0]          PTR_ZERO = AW'(0);
  localparam logic [DECIM_WIDTH-1:0] DEC_ONE  = DECIM_WIDTH'(1);
  localparam logic [DECIM_WIDTH-1:0] DEC_ZERO = DECIM_WIDTH'(0);
  localparam logic [15:0]            DROP_MAX = 16'hFFFF;
  localparam logic [15:0]            DROP_ONE = 16'h0001;
  localparam logic [15:0]            DROP_ZERO = 16'h0000;
  localparam logic [EW-1:0]          ENTRY_ZERO = EW'(0);

  // Offset-binary to two's complement is an MSB flip followed by sign extension.
  function automatic logic [TDATA_WIDTH-1:0] fmt_sample(input logic [DATA_WIDTH-1:0] s,
                                                        input logic sgn);
    logic [DATA_WIDTH-1:0]  v;
    logic [TDATA_WIDTH-1:0] r;
    v = s;
    if (sgn) begin
      v[DATA_WIDTH-1] = ~s[DATA_WIDTH-1];
    end else begin
      v[DATA_WIDTH-1] = s[DATA_WIDTH-1];
    end
    for (int i = 0; i < TDATA_WIDTH; i++) begin
      if (i < DATA_WIDTH) begin
        r[i] = v[i];
      end else begin
        r[i] = sgn ? v[DATA_WIDTH-1] : 1'b0;
      end
    end
    return r;
  endfunction

  logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d, decim_l_q, decim_l_d, eff_decim_s;
  logic                   keep_s;
  logic [NUM_CH-1:0]      acc_q, acc_d, win_or_s;
  logic [NUM_CH-1:0]      pop_s, full_s, wr_s, drop_s;
  logic [NUM_CH-1:0]      tvalid_q, tvalid_d, tuser_q, tuser_d, sticky_q, sticky_d;
  logic [EW-1:0]          wentry_s [NUM_CH];
  logic [EW-1:0]          head_s   [NUM_CH];
  logic [EW-1:0]          mem_q    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr_q [NUM_CH], rd_ptr_d [NUM_CH];
  logic [AW-1:0]          wr_ptr_q [NUM_CH], wr_ptr_d [NUM_CH];
  logic [CW-1:0]          cnt_q    [NUM_CH], cnt_d    [NUM_CH];
  logic [TDATA_WIDTH-1:0] tdata_q  [NUM_CH], tdata_d  [NUM_CH];
  logic [15:0]            drop_q   [NUM_CH], drop_d   [NUM_CH];

  // Shared decimation phase; the ratio is captured at every keep cycle.
  always_comb begin
    dcnt_d      = dcnt_q;
    decim_l_d   = decim_l_q;
    keep_s      = 1'b0;
    eff_decim_s = (decim > DEC_ONE) ? decim : DEC_ONE;
    if (!enable) begin
      dcnt_d = DEC_ZERO;
    end else if (adc_valid) begin
      if (dcnt_q == DEC_ZERO) begin
        keep_s    = 1'b1;
        decim_l_d = eff_decim_s;
        dcnt_d    = (eff_decim_s == DEC_ONE) ? DEC_ZERO : DEC_ONE;
      end else if (dcnt_q == decim_l_q - DEC_ONE) begin
        dcnt_d = DEC_ZERO;
      end else begin
        dcnt_d = dcnt_q + DEC_ONE;
      end
    end else begin
      dcnt_d = dcnt_q;
    end
  end

  // Overrange accumulated across the decimation window, restarted after each keep.
  always_comb begin
    win_or_s = acc_q | adc_or;
    if (!enable) begin
      acc_d = {NUM_CH{1'b0}};
    end else if (adc_valid) begin
      acc_d = keep_s ? {NUM_CH{1'b0}} : win_or_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Per-channel FIFO control, next head word and drop accounting.
  always_comb begin
    pop_s    = {NUM_CH{1'b0}};
    full_s   = {NUM_CH{1'b0}};
    wr_s     = {NUM_CH{1'b0}};
    drop_s   = {NUM_CH{1'b0}};
    tvalid_d = {NUM_CH{1'b0}};
    tuser_d  = {NUM_CH{1'b0}};
    sticky_d = sticky_q;
    for (int c = 0; c < NUM_CH; c++) begin
      pop_s[c]    = tvalid_q[c] & m_axis_tready[c];
      full_s[c]   = (cnt_q[c] == FULL_LVL);
      wr_s[c]     = keep_s & (~full_s[c] | pop_s[c]);
      drop_s[c]   = keep_s & full_s[c] & ~pop_s[c];
      wentry_s[c] = {win_or_s[c], fmt_sample(adc_data[c*DATA_WIDTH +: DATA_WIDTH], fmt_signed)};
      wr_ptr_d[c] = wr_s[c]  ? wr_ptr_q[c] + PTR_ONE : wr_ptr_q[c];
      rd_ptr_d[c] = pop_s[c] ? rd_ptr_q[c] + PTR_ONE : rd_ptr_q[c];
      case ({wr_s[c], pop_s[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CNT_ONE;
        2'b01:   cnt_d[c] = cnt_q[c] - CNT_ONE;
        default: cnt_d[c] = cnt_q[c];
      endcase
      // The word being written is the new head when it lands at the next read slot.
      if (cnt_d[c] == CNT_ZERO) begin
        head_s[c] = ENTRY_ZERO;
      end else if (wr_s[c] && (wr_ptr_q[c] == rd_ptr_d[c])) begin
        head_s[c] = wentry_s[c];
      end else begin
        head_s[c] = mem_q[c][rd_ptr_d[c]];
      end
      tvalid_d[c] = (cnt_d[c] != CNT_ZERO);
      tdata_d[c]  = head_s[c][TDATA_WIDTH-1:0];
      tuser_d[c]  = head_s[c][TDATA_WIDTH];
      if (or_clear) begin
        drop_d[c]   = drop_s[c] ? DROP_ONE : DROP_ZERO;
        sticky_d[c] = drop_s[c];
      end else if (drop_s[c]) begin
        drop_d[c]   = (drop_q[c] == DROP_MAX) ? drop_q[c] : drop_q[c] + DROP_ONE;
        sticky_d[c] = 1'b1;
      end else begin
        drop_d[c]   = drop_q[c];
        sticky_d[c] = sticky_q[c];
      end
    end
  end

  // FIFO storage; contents are don't-care until written so no reset is needed.
  always_ff @(posedge m_axis_aclk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_s[c]) begin
        mem_q[c][wr_ptr_q[c]] <= wentry_s[c];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      dcnt_q    <= DEC_ZERO;
      decim_l_q <= DEC_ONE;
      acc_q     <= {NUM_CH{1'b0}};
      tvalid_q  <= {NUM_CH{1'b0}};
      tuser_q   <= {NUM_CH{1'b0}};
      sticky_q  <= {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr_q[c] <= PTR_ZERO;
        wr_ptr_q[c] <= PTR_ZERO;
        cnt_q[c]    <= CNT_ZERO;
        tdata_q[c]  <= {TDATA_WIDTH{1'b0}};
        drop_q[c]   <= DROP_ZERO;
      end
    end else begin
      dcnt_q    <= dcnt_d;
      decim_l_q <= decim_l_d;
      acc_q     <= acc_d;
      tvalid_q  <= tvalid_d;
      tuser_q   <= tuser_d;
      sticky_q  <= sticky_d;
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr_q[c] <= rd_ptr_d[c];
        wr_ptr_q[c] <= wr_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
        tdata_q[c]  <= tdata_d[c];
        drop_q[c]   <= drop_d[c];
      end
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign ovf_sticky    = sticky_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign m_axis_tdata[g*TDATA_WIDTH +: TDATA_WIDTH] = tdata_q[g];
    assign drop_count[g*16 +: 16]                     = drop_q[g];
  end

endmodule

// File: tb/tb_adc_stream_pack.sv
// Self-checking bench for adc_stream_pack: queue-based reference model compared
// every cycle, directed scenarios pinned with literal expectations, then random traffic.
module tb_adc_stream_pack;

  localparam int NCH = 2;
  localparam int DW  = 14;
  localparam int TW  = 16;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic            fmt_signed = 1'b0;
  logic [7:0]      decim = 8'd1;
  logic            adc_valid = 1'b0;
  logic [NCH*DW-1:0] adc_data = '0;
  logic [NCH-1:0]  adc_or = '0;
  logic            or_clear = 1'b0;
  logic [NCH-1:0]  tvalid;
  logic [NCH-1:0]  tready = '1;
  logic [NCH*TW-1:0] tdata;
  logic [NCH-1:0]  tuser;
  logic [NCH-1:0]  sticky;
  logic [NCH*16-1:0] dcount;

  adc_stream_pack #(.NUM_CH(NCH), .DATA_WIDTH(DW), .TDATA_WIDTH(TW),
                    .FIFO_DEPTH(DEPTH), .DECIM_WIDTH(8)) dut (
    .m_axis_aclk(clk), .m_axis_areset(rst), .enable(enable), .fmt_signed(fmt_signed),
    .decim(decim), .adc_valid(adc_valid), .adc_data(adc_data), .adc_or(adc_or),
    .or_clear(or_clear), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser), .ovf_sticky(sticky), .drop_count(dcount));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h at %0t", nm, ch, act, exp, $time);
    end
  endtask

  // Reference model: queue per channel, ratio-based keep selection.
  logic [TW:0]  mq [NCH][$];
  logic [TW:0]  lg [NCH][$];
  logic [NCH-1:0] m_acc;
  logic [15:0]  m_drop [NCH];
  logic [NCH-1:0] m_stk;
  int           m_since = 0;
  int           m_ratio = 1;
  bit           m_keep, m_pop, m_full, m_dropnow;
  logic [TW:0]  m_word;

  function automatic logic [TW-1:0] m_fmt(input logic [DW-1:0] s, input logic sg);
    int v;
    if (sg) v = int'(s) - (1 << (DW-1));
    else    v = int'(s);
    return v[TW-1:0];
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        m_drop[c] = 16'h0000;
      end
      m_acc = '0; m_stk = '0; m_since = 0; m_ratio = 1;
    end else begin
      m_keep = 1'b0;
      if (!enable) begin
        m_since = 0;
        m_acc = '0;
      end else if (adc_valid) begin
        if (m_since == 0) begin
          m_keep = 1'b1;
          m_ratio = (decim < 8'd2) ? 1 : int'(decim);
        end
        m_since = (m_since + 1) % m_ratio;
      end
      for (int c = 0; c < NCH; c++) begin
        m_pop = (mq[c].size() > 0) && tready[c];
        m_full = (mq[c].size() == DEPTH);
        m_dropnow = 1'b0;
        if (enable && adc_valid) m_acc[c] = m_acc[c] | adc_or[c];
        if (m_keep) begin
          m_word = {m_acc[c], m_fmt(adc_data[c*DW +: DW], fmt_signed)};
          m_acc[c] = 1'b0;
          m_dropnow = m_full && !m_pop;
        end
        if (m_pop) void'(mq[c].pop_front());
        if (m_keep && !m_dropnow) mq[c].push_back(m_word);
        if (or_clear) begin
          m_drop[c] = m_dropnow ? 16'h0001 : 16'h0000;
          m_stk[c] = m_dropnow;
        end else if (m_dropnow) begin
          m_stk[c] = 1'b1;
          if (m_drop[c] != 16'hFFFF) m_drop[c] = m_drop[c] + 16'h0001;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_on && !rst) begin
      for (int c = 0; c < NCH; c++) begin
        chk("tvalid", c, 32'(tvalid[c]), 32'(mq[c].size() != 0));
        if (mq[c].size() != 0) begin
          chk("tdata", c, 32'(tdata[c*TW +: TW]), 32'(mq[c][0][TW-1:0]));
          chk("tuser", c, 32'(tuser[c]), 32'(mq[c][0][TW]));
        end
        chk("ovf_sticky", c, 32'(sticky[c]), 32'(m_stk[c]));
        chk("drop_count", c, 32'(dcount[c*16 +: 16]), 32'(m_drop[c]));
      end
    end
  end

  // Log of words actually transferred, used by the directed checks.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (tvalid[c] && tready[c]) lg[c].push_back({tuser[c], tdata[c*TW +: TW]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int c = 0; c < NCH; c++) lg[c].delete();
  endtask

  logic [DW-1:0] fv [3];
  logic [TW-1:0] fe [3];
  logic [TW-1:0] de [4];
  logic          du [4];
  int rdy_pct;

  initial begin
    fv = '{14'h0000, 14'h2000, 14'h3FFF};
    fe = '{16'hE000, 16'h0000, 16'h1FFF};
    de = '{16'd0, 16'd4, 16'd8, 16'd12};
    du = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    step(); step();
    chk("reset_tvalid", 0, 32'(tvalid), 32'h0);
    chk("reset_tdata", 0, 32'(tdata), 32'h0);
    chk("reset_tuser", 0, 32'(tuser), 32'h0);
    chk("reset_sticky", 0, 32'(sticky), 32'h0);
    chk("reset_drop", 0, 32'(dcount), 32'h0);
    rst = 1'b0;
    chk_on = 1'b1;
    enable = 1'b1;

    // Ramp, keep all
    clear_logs();
    for (int i = 0; i < 12; i++) begin
      adc_valid = 1'b1;
      adc_data = {14'(1000 + i), 14'(i)};
      step();
      if (i == 0) begin
        chk("ramp_first_valid", 0, 32'(tvalid[0]), 32'h1);
        chk("ramp_first_data", 0, 32'(tdata[15:0]), 32'h0);
      end
    end
    adc_valid = 1'b0;
    repeat (3) step();
    chk("ramp_count", 0, 32'(lg[0].size()), 32'd12);
    for (int i = 0; i < 12; i++) chk("ramp_word", 0, 32'(lg[0][i]), 32'(i));
    chk("ramp_drop", 0, 32'(dcount[15:0]), 32'h0);

    // Formatting
    clear_logs();
    fmt_signed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adc_valid = 1'b1;
      adc_data = {fv[i], 14'h0000};
      step();
    end
    adc_valid = 1'b0;
    repeat (3) step();
    chk("fmt_count", 1, 32'(lg[1].size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("fmt_word", 1, 32'(lg[1][i][TW-1:0]), 32'(fe[i]));
    fmt_signed = 1'b0;

    // Decimation by 4 with overrange on sample 6
    enable = 1'b0; step(); enable = 1'b1;
    decim = 8'd4;
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      adc_valid = 1'b1;
      adc_data = {14'h0000, 14'(i)};
      adc_or = (i == 6) ? 2'b01 : 2'b00;
      step();
    end
    adc_valid = 1'b0; adc_or = 2'b00;
    repeat (3) step();
    chk("decim_count", 0, 32'(lg[0].size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("decim_word", 0, 32'(lg[0][i][TW-1:0]), 32'(de[i]));
      chk("decim_tuser", 0, 32'(lg[0][i][TW]), 32'(du[i]));
    end
    enable = 1'b0; step(); enable = 1'b1;
    decim = 8'd1;

    // Backpressure on ch0
    clear_logs();
    tready = 2'b10;
    for (int i = 0; i < 20; i++) begin
      adc_valid = 1'b1;
      adc_data = {14'(i), 14'(100 + i)};
      step();
    end
    adc_valid = 1'b0;
    step();
    chk("bp_drop0", 0, 32'(dcount[15:0]), 32'd4);
    chk("bp_sticky0", 0, 32'(sticky[0]), 32'h1);
    chk("bp_drop1", 1, 32'(dcount[31:16]), 32'd0);
    chk("bp_sticky1", 1, 32'(sticky[1]), 32'h0);
    tready = 2'b11;
    repeat (20) step();
    chk("bp_count", 0, 32'(lg[0].size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("bp_word", 0, 32'(lg[0][i]), 32'(100 + i));
    or_clear = 1'b1; step(); or_clear = 1'b0;
    chk("clr_drop0", 0, 32'(dcount[15:0]), 32'd0);
    chk("clr_sticky0", 0, 32'(sticky[0]), 32'h0);

    // Full FIFO with simultaneous pop, then drop coincident with or_clear
    clear_logs();
    tready = 2'b10;
    for (int i = 0; i < 16; i++) begin
      adc_valid = 1'b1;
      adc_data = {14'h0000, 14'(200 + i)};
      step();
    end
    adc_data = {14'h0000, 14'd216};
    tready = 2'b11;
    step();
    tready = 2'b10; adc_valid = 1'b0;
    chk("fullpop_nodrop", 0, 32'(dcount[15:0]), 32'd0);
    adc_valid = 1'b1; adc_data = {14'h0000, 14'd217};
    step();
    chk("still_full_drop", 0, 32'(dcount[15:0]), 32'd1);
    adc_data = {14'h0000, 14'd218}; or_clear = 1'b1;
    step();
    adc_valid = 1'b0; or_clear = 1'b0;
    chk("clr_with_drop", 0, 32'(dcount[15:0]), 32'd1);
    chk("clr_with_drop_sticky", 0, 32'(sticky[0]), 32'h1);
    tready = 2'b11;
    repeat (20) step();
    chk("fullpop_count", 0, 32'(lg[0].size()), 32'd17);
    for (int i = 0; i < 17; i++) chk("fullpop_word", 0, 32'(lg[0][i]), 32'(200 + i));
    or_clear = 1'b1; step(); or_clear = 1'b0;

    // Asynchronous reset with words queued
    tready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      adc_valid = 1'b1;
      adc_data = {14'h0000, 14'(300 + i)};
      step();
    end
    adc_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst_tvalid", 0, 32'(tvalid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tready = 2'b11;
    adc_valid = 1'b1; adc_data = {14'h0000, 14'd400};
    step();
    adc_valid = 1'b0;
    chk("post_rst_valid", 0, 32'(tvalid[0]), 32'h1);
    chk("post_rst_data", 0, 32'(tdata[15:0]), 32'd400);
    step();
    chk("post_rst_empty", 0, 32'(tvalid[0]), 32'h0);

    // Random traffic
    for (int blk = 0; blk < 30; blk++) begin
      decim = 8'($urandom_range(0, 5));
      fmt_signed = 1'($urandom_range(0, 1));
      rdy_pct = $urandom_range(10, 100);
      for (int i = 0; i < 100; i++) begin
        adc_valid = ($urandom_range(0, 3) != 0);
        enable = ($urandom_range(0, 29) != 0);
        adc_data = NCH*DW'($urandom);
        adc_or = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
        or_clear = ($urandom_range(0, 63) == 0);
        for (int c = 0; c < NCH; c++) tready[c] = ($urandom_range(1, 100) <= rdy_pct);
        step();
      end
    end
    adc_valid = 1'b0; or_clear = 1'b0; tready = 2'b11;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
